// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial-pattern detector.
package seq_det_pkg;

    localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;

    localparam logic OVL_OFF = 1'b0;
    localparam logic OVL_ON  = 1'b1;

    // Ceiling log2; the detector always calls it with an argument >= 2.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_det_sat_counter.sv
// Match counter: synchronous clear beats increment, and the count saturates at all-ones.
module seq_det_sat_counter #(
    parameter int CNT_W = 8
)(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [CNT_W-1:0] count_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/seq_detector_param.sv
// Moore serial-pattern detector with a runtime-loadable pattern, selectable overlap
// and a saturating match counter.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = PAT_W'(DEFAULT_PATTERN),
    parameter int               CNT_W   = 8
)(
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          x,
    input  logic                          in_valid,
    input  logic                          overlap_en,
    input  logic                          pat_load,
    input  logic [PAT_W-1:0]              pat_in,
    input  logic                          count_clr,
    output logic                          y,
    output logic [clog2(PAT_W+1)-1:0]     state,
    output logic [CNT_W-1:0]              match_count
);

    localparam int            SW       = clog2(PAT_W + 1);
    localparam logic [SW-1:0] MATCH_ST = SW'(PAT_W);

    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] hist_q;
    logic [PAT_W-1:0] hist_d;
    logic [PAT_W:0]   hist_ext;
    logic [PAT_W-1:0] mask;
    logic [SW-1:0]    state_q;
    logic [SW-1:0]    state_d;
    logic             y_q;
    logic             accept;
    logic             inc;

    // A bit arriving alongside a pattern load is dropped.
    assign accept   = in_valid && !pat_load;
    assign hist_ext = {hist_q, x};
    assign hist_d   = hist_ext[PAT_W-1:0];

    // Longest suffix of the history that is a pattern prefix, capped at state_q+1 so
    // bits from before the last restart point never contribute.
    always_comb begin
        state_d = state_q;
        mask    = '0;
        if (accept) begin
            if ((state_q == MATCH_ST) && (overlap_en == OVL_OFF)) begin
                state_d = (x == pat_q[PAT_W-1]) ? SW'(1) : '0;
            end else begin
                state_d = '0;
                for (int k = 1; k <= PAT_W; k++) begin
                    mask = {PAT_W{1'b1}} >> (PAT_W - k);
                    if ((k <= int'(state_q) + 1) &&
                        ((hist_d & mask) == ((pat_q >> (PAT_W - k)) & mask))) begin
                        state_d = SW'(k);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pat_q   <= PATTERN;
            hist_q  <= '0;
            state_q <= '0;
            y_q     <= 1'b0;
        end else if (pat_load) begin
            pat_q   <= pat_in;
            hist_q  <= '0;
            state_q <= '0;
            y_q     <= 1'b0;
        end else if (accept) begin
            hist_q  <= hist_d;
            state_q <= state_d;
            y_q     <= (state_d == MATCH_ST);
        end
    end

    // Every accepted bit that lands in the match state counts, including re-entry.
    assign inc = accept && (state_d == MATCH_ST);

    seq_det_sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk_i   (clk),
        .rst_i   (rst),
        .clr_i   (count_clr),
        .inc_i   (inc),
        .count_o (match_count)
    );

    assign y     = y_q;
    assign state = state_q;

endmodule
